riscv_muldiv_unit: RTL and testbench
====================================

# riscv_muldiv_unit

Iterative multiply/divide execute unit implementing the RV32M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in datapath width.
- Sits beside the single-cycle ALU in the execute stage and receives operands from the register file through a valid/ready handshake.
- Returns one result plus a pass-through destination tag.
- Computes one radix-2 step per cycle.
- Resolves RISC-V divide special cases without iterating.

## Interface
Parameters:
- DATA_WIDTH, 32: operand/result width W. Must be even and ≥ 4.
- TAG_WIDTH, REG_ADDR (5): width of the pass-through tag, normally rd.

Ports:
- clk  in  1  clock. Single clock domain; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request. High only in IDLE.
- in_op  in  3  mdOpType, equal to instruction funct3.
- in_rs1  in  W  dividend / multiplicand.
- in_rs2  in  W  divisor / multiplier.
- in_tag  in  TAG_WIDTH  destination tag, captured at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  result.
- out_tag  out  TAG_WIDTH  tag of the operation that produced out_result.
- busy  out  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE.
- Accept: in_valid && in_ready at a rising edge. Captures op, operands and tag; IDLE→BUSY with counter=0.
- Special cases on accept go IDLE→DONE directly, with no iteration:
  - DIV/DIVU by zero: quotient = all ones.
  - REM/REMU by zero: remainder = rs1.
  - DIV of −2^(W−1) by −1: result −2^(W−1). REM of the same: result 0.
- Operand conditioning on accept:
  - Signed operands are converted to magnitudes: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned.
  - The result sign is recorded: for products, XOR of the operand signs; for quotients, XOR of the signs; for remainders, the dividend sign.
- BUSY: one iteration per cycle, W iterations, counter 0..W−1. Counter width is $clog2(W)+1.
  - Multiply: shift-add into a 2W-bit product.
  - Divide: restoring division; W-bit remainder register plus one guard bit.
- At the edge completing iteration W−1: apply sign correction (two's complement of the 2W product, quotient or remainder as recorded), register the result, BUSY→DONE.
- Result selection: MUL returns product[W−1:0]; MULH/MULHSU/MULHU return product[2W−1:W]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: out_valid=1. out_result and out_tag are registered and stay stable until out_valid && out_ready, which moves DONE→IDLE.
- in_ready is 0 in DONE. No accept happens in the same cycle as result handoff.
- flush=1 at an edge: any state→IDLE, out_valid=0, captured result discarded. If in_valid is high in the same cycle, flush wins and the request is not accepted.
- in_op values are exhaustive (3 bits); no illegal op exists.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, out_tag=0, counter=0. Reset is honoured mid-operation with no partial result.
- Normal ops: out_valid rises W+1 cycles after the accept edge; for W=32, 33 cycles.
- Special-case divides: out_valid rises in the cycle after the accept edge (latency 1).
- Throughput, no backpressure: one operation per W+2 cycles; accept, W iterations, handoff cycle.
- in_ready, busy and out_valid are decoded from registered state only; no input-to-output combinational path.
- out_ready held low: the unit stalls indefinitely in DONE with outputs frozen.

## Structure
Add to riscv_definitions:
- mdOpType enum (logic [2:0]), values equal to funct3: MD_MUL=000, MD_MULH=001, MD_MULHSU=010, MD_MULHU=011, MD_DIV=100, MD_DIVU=101, MD_REM=110, MD_REMU=111.
- localparam MULDIV_FUNCT7 = 7'b0000001, for decode.
- mdState_e enum: MD_IDLE, MD_BUSY, MD_DONE.

Sub-module riscv_muldiv_sign (combinational): magnitude extraction and final two's-complement correction. Used at both ends of the datapath.

## Test plan
All values are for W=32.
- MUL 7 × 0xFFFFFFFD (−3) → out_result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; out_tag equals in_tag (e.g. 5'd17).
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with latency 1:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid, out_result and out_tag must be stable and in_ready=0 throughout. Raise out_ready: IDLE and in_ready=1 the next cycle.
- Abort: flush at iteration 10 of a DIV with in_valid=1 in the same cycle. Expect IDLE next cycle, no out_valid, request not accepted. A following MULHU 3×5 returns 0. Repeat with rst_n pulsed low mid-BUSY; expect all reset values.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// Shared RISC-V definitions: M-extension op encodings and muldiv FSM states.
package riscv_definitions;

  localparam int REG_ADDR = 5;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  // Encodings equal instruction funct3 so decode can pass funct3 straight through.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mdOpType;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdState_e;

endpackage

// File: rtl/riscv_muldiv_sign.sv
// Conditional two's-complement: magnitude extraction on entry, sign fix on exit.
module riscv_muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one step per cycle, with divide special cases short-cut.
module riscv_muldiv_unit
  import riscv_definitions::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = REG_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  mdState_e              state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  mdOpType               op_q, op_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  neg_q, neg_d;
  logic [W-1:0]          opb_q, opb_d;
  logic [2*W-1:0]        acc_q, acc_d;
  logic [W-1:0]          res_q, res_d;

  mdOpType    op_in;
  logic       s1, s2, n1, n2;
  logic [W-1:0] mag1, mag2;
  logic       div_zero, div_ovf;
  logic [W-1:0] spec_res;

  assign op_in = mdOpType'(in_op);
  assign s1 = (op_in == MD_MULH) || (op_in == MD_MULHSU) || (op_in == MD_DIV) || (op_in == MD_REM);
  assign s2 = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
  assign n1 = s1 & in_rs1[W-1];
  assign n2 = s2 & in_rs2[W-1];

  riscv_muldiv_sign #(.WIDTH(W)) u_mag1 (.val_i(in_rs1), .neg_i(n1), .val_o(mag1));
  riscv_muldiv_sign #(.WIDTH(W)) u_mag2 (.val_i(in_rs2), .neg_i(n2), .val_o(mag2));

  assign div_zero = in_op[2] && (in_rs2 == '0);
  assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (in_rs1 == {1'b1, {(W-1){1'b0}}}) && (in_rs2 == '1);
  // Overflow DIV returns the dividend itself (-2^(W-1)); REM returns 0.
  assign spec_res = div_zero ? (in_op[1] ? in_rs1 : '1)
                             : (in_op[1] ? '0 : in_rs1);

  // Multiply: acc = {partial high, remaining multiplier bits}.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; guard bit lives in div_shift.
  logic [W:0]     div_shift, div_diff;
  logic           div_ok;
  logic [2*W-1:0] div_next;
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ok    = ~div_diff[W];
  assign div_next  = {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ok};

  logic [2*W-1:0] step_next, fix_in, fix_out;
  logic [W-1:0]   fin_res;
  assign step_next = op_q[2] ? div_next : mul_next;
  // Divide results are zero-extended so the 2W negation yields the W-bit negation.
  assign fix_in    = op_q[2] ? {{W{1'b0}}, (op_q[1] ? step_next[2*W-1:W] : step_next[W-1:0])}
                             : step_next;

  riscv_muldiv_sign #(.WIDTH(2*W)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

  assign fin_res = (op_q[2] || (op_q[1:0] == 2'b00)) ? fix_out[W-1:0] : fix_out[2*W-1:W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            op_d  = op_in;
            tag_d = in_tag;
            neg_d = (op_in == MD_REM) ? n1 : (n1 ^ n2);
            opb_d = in_op[2] ? mag2 : mag1;
            acc_d = {{W{1'b0}}, (in_op[2] ? mag1 : mag2)};
            cnt_d = '0;
            if (div_zero || div_ovf) begin
              res_d   = spec_res;
              state_d = MD_DONE;
            end else begin
              state_d = MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          acc_d = step_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) begin
            res_d   = fin_res;
            cnt_d   = '0;
            state_d = MD_DONE;
          end
        end
        MD_DONE: begin
          if (out_ready) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == MD_IDLE);
  assign busy       = (state_q != MD_IDLE);
  assign out_valid  = (state_q == MD_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed-vector bench for riscv_muldiv_unit at W=32.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks = 0;
  int failures = 0;

  riscv_muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its result; hands off only if out_ready is high.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({name, "_ready"}, in_ready, 1'b1);
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, out_result, exp);
    chk({name, "_tag"}, out_tag, tg);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({name, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    end
  endtask

  initial begin
    int seen_valid;
    #12;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_tag", out_tag, 5'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd17, 32'hFFFFFFEB, 33);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        33);
    run_op("div0",   3'd4, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1);
    run_op("rem0",   3'd6, 32'd5,        32'd0,        5'd9,  32'd5,        1);
    run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1);
    run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h0,        1);

    // Flush at iteration 10 of a DIV, with a competing request in the same cycle.
    @(negedge clk);
    in_op = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_tag = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    in_op = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'd13;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", {in_ready, out_valid, busy}, 3'b100);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen_valid++;
    end
    chk("flush_quiet", seen_valid, 0);
    run_op("mulhu_post", 3'd3, 32'd3, 32'd5, 5'd14, 32'd0, 33);

    // Backpressure: result must freeze in DONE while out_ready is low.
    out_ready = 1'b0;
    run_op("bp", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {in_ready, out_valid, busy, out_tag, out_result}, {3'b011, 5'd9, 32'd14});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {in_ready, out_valid, busy}, 3'b100);

    // Reset pulsed mid-BUSY.
    @(negedge clk);
    in_op = 3'd5; in_rs1 = 32'd77; in_rs2 = 32'd5; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("mid_rst_result", out_result, 32'h0);
    chk("mid_rst_tag", out_tag, 5'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 3'd5, 32'd77, 32'd5, 5'd21, 32'd15, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
